// File: rtl/decade_cascade_ctrl.sv
// Run/pause/done controller for a cascade of prescaled BCD decade counters.
// Stops once the post-update count equals the programmed BCD target.
module decade_cascade_ctrl #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 10,
  localparam int PW = $clog2(PRESCALE + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   clear,
  input  logic [4*NDIGITS-1:0]   target,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     dig_ena,
  output logic                   wrap,
  output logic                   running,
  output logic                   done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [1:0]           state;
  logic [PW-1:0]        presc;
  logic [4*NDIGITS-1:0] digits_nx;
  logic [NDIGITS:0]     cy;
  logic                 tick;

  assign tick = (state == S_RUN) & ~stop & ~clear
              & (presc == PMAX);

  // cy[i] enables digit i; cy[NDIGITS] is the roll-over of the whole count
  always_comb begin
    cy        = '0;
    digits_nx = digits;
    cy[0]     = tick;
    for (int i = 0; i < NDIGITS; i++) begin
      cy[i+1] = cy[i] & (digits[4*i +: 4] == 4'd9);
      if (cy[i]) begin
        if (digits[4*i +: 4] == 4'd9)
          digits_nx[4*i +: 4] = 4'd0;
        else
          digits_nx[4*i +: 4] = digits[4*i +: 4] + 4'd1;
      end
    end
  end

  assign dig_ena = cy[NDIGITS-1:0];
  assign wrap    = cy[NDIGITS];
  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      presc  <= '0;
      digits <= '0;
    end else if (clear) begin
      state  <= S_IDLE;
      presc  <= '0;
      digits <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            presc <= '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state <= S_PAUSE;
          end else begin
            presc  <= (presc == PMAX) ? '0 : presc + PW'(1);
            digits <= digits_nx;
            if (tick && digits_nx == target)
              state <= S_DONE;
          end
        end
        S_PAUSE: begin
          if (start)
            state <= S_RUN;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decade_cascade_ctrl.sv
// Scoreboard bench for decade_cascade_ctrl: three instances with
// different prescales, expectations queued per edge and checked on arrival.
module tb_decade_cascade_ctrl;

  localparam int F_DIG  = 0;
  localparam int F_DONE = 1;
  localparam int F_RUN  = 2;
  localparam int F_WRAP = 3;
  localparam int F_ENA  = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start   [3];
  logic       stop    [3];
  logic       clear   [3];
  logic [7:0] target  [3];
  logic [7:0] digits  [3];
  logic [1:0] dig_ena [3];
  logic       wrap    [3];
  logic       running [3];
  logic       done    [3];

  always #5 clk = ~clk;

  decade_cascade_ctrl #(.NDIGITS(2), .PRESCALE(3)) u0 (
    .clk(clk), .reset_n(reset_n),
    .start(start[0]), .stop(stop[0]), .clear(clear[0]),
    .target(target[0]), .digits(digits[0]),
    .dig_ena(dig_ena[0]), .wrap(wrap[0]),
    .running(running[0]), .done(done[0])
  );

  decade_cascade_ctrl #(.NDIGITS(2), .PRESCALE(4)) u1 (
    .clk(clk), .reset_n(reset_n),
    .start(start[1]), .stop(stop[1]), .clear(clear[1]),
    .target(target[1]), .digits(digits[1]),
    .dig_ena(dig_ena[1]), .wrap(wrap[1]),
    .running(running[1]), .done(done[1])
  );

  decade_cascade_ctrl #(.NDIGITS(2), .PRESCALE(1)) u2 (
    .clk(clk), .reset_n(reset_n),
    .start(start[2]), .stop(stop[2]), .clear(clear[2]),
    .target(target[2]), .digits(digits[2]),
    .dig_ena(dig_ena[2]), .wrap(wrap[2]),
    .running(running[2]), .done(done[2])
  );

  typedef struct {
    int    inst;
    int    e;
    int    f;
    int    val;
    string tag;
  } sb_t;

  sb_t sb[$];
  int  n;
  int  tests = 0;
  int  fails = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(int i, int f);
    case (f)
      F_DIG:   return 32'(digits[i]);
      F_DONE:  return 32'(done[i]);
      F_RUN:   return 32'(running[i]);
      F_WRAP:  return 32'(wrap[i]);
      default: return 32'(dig_ena[i]);
    endcase
  endfunction

  task automatic expect_at(int i, int e, int f, int v,
                           string tag);
    sb_t s;
    s.inst = i;
    s.e    = e;
    s.f    = f;
    s.val  = v;
    s.tag  = tag;
    sb.push_back(s);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].e <= n) begin
        check($sformatf("%s@%0d", sb[k].tag, sb[k].e),
              obs(sb[k].inst, sb[k].f), 32'(sb[k].val));
        sb.delete(k);
      end
    end
  endtask

  task automatic begin_run(int i);
    n = -1;
    start[i] = 1'b1;
    step();
    start[i] = 1'b0;
  endtask

  task automatic do_clear(int i);
    clear[i] = 1'b1;
    step();
    clear[i] = 1'b0;
  endtask

  task automatic drain(string tag);
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start[i]  = 1'b0;
      stop[i]   = 1'b0;
      clear[i]  = 1'b0;
      target[i] = 8'h99;
    end
    reset_n = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_dig%0d", i), 32'(digits[i]), 0);
      check($sformatf("rst_run%0d", i), 32'(running[i]), 0);
      check($sformatf("rst_done%0d", i), 32'(done[i]), 0);
      check($sformatf("rst_ena%0d", i), 32'(dig_ena[i]), 0);
    end
    reset_n = 1'b1;

    // count to 12 with prescale 3, including the 09 -> 10 carry
    target[0] = 8'h12;
    expect_at(0, 0,  F_RUN,  1,     "t1_run");
    expect_at(0, 2,  F_DIG,  0,     "t1_dig");
    expect_at(0, 2,  F_ENA,  1,     "t1_ena");
    expect_at(0, 3,  F_DIG,  1,     "t1_dig");
    expect_at(0, 28, F_ENA,  0,     "t2_ena");
    expect_at(0, 29, F_DIG,  9,     "t2_dig");
    expect_at(0, 29, F_ENA,  3,     "t2_ena");
    expect_at(0, 29, F_WRAP, 0,     "t2_wrap");
    expect_at(0, 30, F_DIG,  'h10,  "t2_dig");
    expect_at(0, 35, F_DIG,  'h11,  "t1_dig");
    expect_at(0, 35, F_DONE, 0,     "t1_done");
    expect_at(0, 36, F_DIG,  'h12,  "t1_dig");
    expect_at(0, 36, F_DONE, 1,     "t1_done");
    expect_at(0, 36, F_RUN,  0,     "t1_run");
    expect_at(0, 56, F_DIG,  'h12,  "t1_hold");
    expect_at(0, 56, F_DONE, 1,     "t1_hold");
    begin_run(0);
    repeat (56) step();
    drain("t1");
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    check("t1_start_in_done", 32'(done[0]), 1);
    check("t1_dig_in_done", 32'(digits[0]), 'h12);
    do_clear(0);
    check("t1_clear_dig", 32'(digits[0]), 0);
    check("t1_clear_done", 32'(done[0]), 0);

    // pause with prescaler at 2 preserves phase
    expect_at(1, 4,  F_DIG, 1, "t3_dig");
    expect_at(1, 6,  F_DIG, 1, "t3_dig");
    expect_at(1, 7,  F_RUN, 0, "t3_run");
    expect_at(1, 26, F_DIG, 1, "t3_frozen");
    expect_at(1, 26, F_RUN, 0, "t3_run");
    expect_at(1, 27, F_RUN, 1, "t3_resume");
    expect_at(1, 28, F_DIG, 1, "t3_dig");
    expect_at(1, 29, F_DIG, 2, "t3_dig");
    expect_at(1, 33, F_DIG, 3, "t3_dig");
    begin_run(1);
    repeat (6) step();
    stop[1] = 1'b1;
    repeat (20) step();
    stop[1] = 1'b0;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    repeat (6) step();
    drain("t3");

    // prescale 1, target 00 reached only via wrap
    target[2] = 8'h00;
    expect_at(2, 1,   F_DIG,  1,    "t4_dig");
    expect_at(2, 50,  F_DIG,  'h50, "t4_dig");
    expect_at(2, 98,  F_WRAP, 0,    "t4_wrap");
    expect_at(2, 99,  F_DIG,  'h99, "t4_dig");
    expect_at(2, 99,  F_WRAP, 1,    "t4_wrap");
    expect_at(2, 99,  F_ENA,  3,    "t4_ena");
    expect_at(2, 99,  F_DONE, 0,    "t4_done");
    expect_at(2, 100, F_DIG,  0,    "t4_dig");
    expect_at(2, 100, F_DONE, 1,    "t4_done");
    expect_at(2, 100, F_RUN,  0,    "t4_run");
    begin_run(2);
    repeat (100) step();
    drain("t4");
    do_clear(2);

    // illegal target nibble never matches
    target[2] = 8'h0A;
    expect_at(2, 150, F_DIG,  'h50, "t4b_dig");
    expect_at(2, 150, F_DONE, 0,    "t4b_done");
    expect_at(2, 150, F_RUN,  1,    "t4b_run");
    begin_run(2);
    repeat (150) step();
    drain("t4b");
    do_clear(2);

    // clear beats stop and start
    target[0] = 8'h99;
    expect_at(0, 7,  F_DIG, 2, "t5_dig");
    expect_at(0, 8,  F_DIG, 0, "t5_clr_dig");
    expect_at(0, 8,  F_RUN, 0, "t5_clr_run");
    expect_at(0, 9,  F_RUN, 1, "t5_rerun");
    expect_at(0, 11, F_DIG, 0, "t5_dig");
    expect_at(0, 12, F_DIG, 1, "t5_dig");
    begin_run(0);
    repeat (7) step();
    clear[0] = 1'b1;
    stop[0]  = 1'b1;
    start[0] = 1'b1;
    step();
    clear[0] = 1'b0;
    stop[0]  = 1'b0;
    step();
    start[0] = 1'b0;
    repeat (3) step();
    drain("t5");
    do_clear(0);

    // async reset mid-count
    expect_at(0, 111, F_DIG, 'h37, "t6_dig");
    begin_run(0);
    repeat (111) step();
    drain("t6a");
    #3 reset_n = 1'b0;
    #1;
    check("t6_rst_dig", 32'(digits[0]), 0);
    check("t6_rst_run", 32'(running[0]), 0);
    check("t6_rst_done", 32'(done[0]), 0);
    #2 reset_n = 1'b1;
    expect_at(0, 0, F_RUN, 1, "t6_run");
    expect_at(0, 2, F_DIG, 0, "t6_dig");
    expect_at(0, 3, F_DIG, 1, "t6_dig");
    begin_run(0);
    repeat (3) step();
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
